// File: rtl/temp_mon_pkg.sv
// Shared types and constants for the basement temperature alarm monitor.
package temp_mon_pkg;
  localparam int TEMP_W = 13;

  typedef enum logic [1:0] {NORMAL, RISE, ALARM, FALL} state_e;

  // Whole degrees C to the sensor's 1/16 degC two's-complement code.
  function automatic logic signed [TEMP_W-1:0] degC_to_code(input int degc);
    return TEMP_W'(degc * 16);
  endfunction
endpackage

// File: rtl/temp_alarm_monitor_if.sv
// Sample / threshold / alarm bundle between the I2C read stage and the monitor.
// alarm_ack exists only when ALARM_LATCH_EN is defined.
interface temp_alarm_monitor_if;
  import temp_mon_pkg::*;

  logic        [15:0]       temp_raw;
  logic                     temp_valid;
  logic signed [TEMP_W-1:0] thr_high;
  logic signed [TEMP_W-1:0] thr_low;
  logic signed [TEMP_W-1:0] temp_avg;
  logic                     avg_valid;
  logic                     alarm;
`ifdef ALARM_LATCH_EN
  logic                     alarm_ack;

  modport master(output temp_raw, temp_valid, thr_high, thr_low, alarm_ack,
                 input  temp_avg, avg_valid, alarm);
  modport slave (input  temp_raw, temp_valid, thr_high, thr_low, alarm_ack,
                 output temp_avg, avg_valid, alarm);
`else
  modport master(output temp_raw, temp_valid, thr_high, thr_low,
                 input  temp_avg, avg_valid, alarm);
  modport slave (input  temp_raw, temp_valid, thr_high, thr_low,
                 output temp_avg, avg_valid, alarm);
`endif
endinterface

// File: rtl/temp_avg_window.sv
// Sliding-window average of the signed 13-bit temperature: circular buffer,
// running sum and fill flag; one sample per cycle, strobe two cycles after capture.
module temp_avg_window
  import temp_mon_pkg::*;
#(
  parameter int AVG_LOG2 = 2
) (
  input  logic                     clk_fpga,
  input  logic                     reset,
  input  logic [15:0]              raw,
  input  logic                     raw_valid,
  output logic signed [TEMP_W-1:0] avg,
  output logic                     avg_valid
);
  localparam int                    DEPTH  = 1 << AVG_LOG2;
  localparam int                    SUM_W  = TEMP_W + AVG_LOG2;
  localparam int                    STAGES = 2;
  localparam logic [AVG_LOG2-1:0]   LAST   = AVG_LOG2'(DEPTH - 1);

  logic [STAGES:0]           vld_pipe;
  logic signed [TEMP_W-1:0]  s1_temp;
  logic signed [TEMP_W-1:0]  win [DEPTH];
  logic [AVG_LOG2-1:0]       ptr;
  logic                      full;
  logic signed [SUM_W-1:0]   sum;
  logic signed [SUM_W-1:0]   add_ext;
  logic signed [SUM_W-1:0]   sub_ext;
  logic                      unused_lsb;

  assign unused_lsb = ^raw[2:0];

  // Slots not yet written since reset hold stale data; treat them as zero.
  always_comb begin
    add_ext = s1_temp;
    sub_ext = '0;
    if (full) sub_ext = win[ptr];
  end

  always_ff @(posedge clk_fpga) begin
    if (vld_pipe[0]) win[ptr] <= s1_temp;
  end

  always_ff @(posedge clk_fpga or posedge reset) begin
    if (reset) begin
      vld_pipe <= '0;
      s1_temp  <= '0;
      ptr      <= '0;
      full     <= 1'b0;
      sum      <= '0;
      avg      <= '0;
    end else begin
      vld_pipe[0] <= raw_valid;
      if (raw_valid) s1_temp <= raw[15:3];
      if (vld_pipe[0]) begin
        sum <= sum + add_ext - sub_ext;
        ptr <= ptr + 1'b1;
        if (ptr == LAST) full <= 1'b1;
      end
      // The write that completes the first pass already produces a valid average.
      vld_pipe[1] <= vld_pipe[0] & (full | (ptr == LAST));
      vld_pipe[2] <= vld_pipe[1];
      if (vld_pipe[1]) avg <= TEMP_W'(sum >>> AVG_LOG2);
    end
  end

  assign avg_valid = vld_pipe[STAGES];
endmodule

// File: rtl/temp_alarm_monitor.sv
// Windowed temperature average with a debounced, hysteretic over-temperature alarm.
// Define ALARM_LATCH_EN for a sticky alarm latch cleared by alarm_ack in NORMAL.
module temp_alarm_monitor
  import temp_mon_pkg::*;
#(
  parameter int AVG_LOG2 = 2,
  parameter int DEBOUNCE = 3
) (
  input logic                  clk_fpga,
  input logic                  reset,
  temp_alarm_monitor_if.slave  bus
);
  localparam logic [3:0] DEB = 4'(DEBOUNCE);

  logic signed [TEMP_W-1:0] avg;
  logic                     avg_valid;
  state_e                   state, state_nx;
  logic [3:0]               cnt, cnt_nx, cnt_inc;
  logic                     fsm_alarm;

  temp_avg_window #(.AVG_LOG2(AVG_LOG2)) u_window (
    .clk_fpga  (clk_fpga),
    .reset     (reset),
    .raw       (bus.temp_raw),
    .raw_valid (bus.temp_valid),
    .avg       (avg),
    .avg_valid (avg_valid)
  );

  assign bus.temp_avg  = avg;
  assign bus.avg_valid = avg_valid;

  always_ff @(posedge clk_fpga or posedge reset) begin
    if (reset) begin
      state <= NORMAL;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    cnt_inc  = cnt + 4'd1;
    if (avg_valid) begin
      unique case (state)
        NORMAL: if (avg > bus.thr_high) begin
          if (DEB == 4'd1) begin state_nx = ALARM; cnt_nx = '0;   end
          else             begin state_nx = RISE;  cnt_nx = 4'd1; end
        end
        RISE: if (avg > bus.thr_high) begin
          if (cnt_inc == DEB) begin state_nx = ALARM; cnt_nx = '0; end
          else                      cnt_nx = cnt_inc;
        end else begin
          state_nx = NORMAL;
          cnt_nx   = '0;
        end
        ALARM: if (avg < bus.thr_low) begin
          if (DEB == 4'd1) begin state_nx = NORMAL; cnt_nx = '0;   end
          else             begin state_nx = FALL;   cnt_nx = 4'd1; end
        end
        FALL: if (avg < bus.thr_low) begin
          if (cnt_inc == DEB) begin state_nx = NORMAL; cnt_nx = '0; end
          else                      cnt_nx = cnt_inc;
        end else begin
          state_nx = ALARM;
          cnt_nx   = '0;
        end
        default: begin state_nx = NORMAL; cnt_nx = '0; end
      endcase
    end
  end

  assign fsm_alarm = (state == ALARM) || (state == FALL);

`ifdef ALARM_LATCH_EN
  logic latch;

  // Set has priority: an ack while the FSM is leaving NORMAL is dropped.
  always_ff @(posedge clk_fpga or posedge reset) begin
    if (reset)
      latch <= 1'b0;
    else if (state_nx == ALARM && state != ALARM)
      latch <= 1'b1;
    else if (bus.alarm_ack && state == NORMAL && state_nx == NORMAL)
      latch <= 1'b0;
  end

  assign bus.alarm = latch | fsm_alarm;
`else
  assign bus.alarm = fsm_alarm;
`endif
endmodule

// File: tb/tb_temp_alarm_monitor.sv
// Self-checking bench for temp_alarm_monitor against a window/debounce reference model.
module tb_temp_alarm_monitor;
  import temp_mon_pkg::*;

  localparam int AVG_LOG2 = 2;
  localparam int DEBOUNCE = 3;
  localparam int NWIN     = 1 << AVG_LOG2;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   tests = 0;
  int   fails = 0;

  // reference model state
  int win_q[$];
  int nsamp = 0;
  bit m_alarm = 1'b0;
  bit m_latch = 1'b0;
  int m_run = 0;
  int hi = 448;
  int lo = 416;

  temp_alarm_monitor_if bus();

  temp_alarm_monitor #(.AVG_LOG2(AVG_LOG2), .DEBOUNCE(DEBOUNCE)) dut (
    .clk_fpga (clk),
    .reset    (reset),
    .bus      (bus.slave)
  );

  always #5 clk = ~clk;

  function automatic int raw_to_temp(input logic [15:0] r);
    logic signed [12:0] t;
    t = r[15:3];
    return int'(t);
  endfunction

  function automatic logic [15:0] temp_to_raw(input int t);
    logic [12:0] c;
    c = 13'(t);
    return {c, 3'(($urandom & 32'd7))};
  endfunction

  function automatic void model_reset();
    win_q.delete();
    nsamp   = 0;
    m_alarm = 1'b0;
    m_latch = 1'b0;
    m_run   = 0;
  endfunction

  // Pushes one sample; reports whether it yields an average and its value (floor).
  function automatic void model_push(input logic [15:0] r, output bit v, output int a);
    int s;
    win_q.push_back(raw_to_temp(r));
    if (win_q.size() > NWIN) void'(win_q.pop_front());
    nsamp++;
    v = (nsamp >= NWIN);
    a = 0;
    if (v) begin
      s = 0;
      foreach (win_q[i]) s += win_q[i];
      a = (s >= 0) ? s / NWIN : -((-s + NWIN - 1) / NWIN);
      if (!m_alarm) begin
        m_run = (a > hi) ? m_run + 1 : 0;
        if (m_run == DEBOUNCE) begin
          m_alarm = 1'b1;
          m_run   = 0;
`ifdef ALARM_LATCH_EN
          m_latch = 1'b1;
`endif
        end
      end else begin
        m_run = (a < lo) ? m_run + 1 : 0;
        if (m_run == DEBOUNCE) begin
          m_alarm = 1'b0;
          m_run   = 0;
        end
      end
    end
  endfunction

  task automatic set_thr(input int h, input int l);
    hi = h;
    lo = l;
    bus.thr_high = 13'(h);
    bus.thr_low  = 13'(l);
  endtask

  task automatic apply_reset(input string tag);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    tests++;
    if (bus.temp_avg !== 13'd0 || bus.avg_valid !== 1'b0 || bus.alarm !== 1'b0) begin
      fails++;
      $display("FAIL %s: avg=%0d vld=%b alarm=%b, required 0/0/0", tag,
               $signed(bus.temp_avg), bus.avg_valid, bus.alarm);
    end
  endtask

  // One isolated strobe, then check the average strobe and the alarm a cycle later.
  task automatic send_check(input logic [15:0] r, input string tag);
    bit v;
    int a;
    bit al;
    model_push(r, v, a);
    al = m_alarm | m_latch;
    @(negedge clk);
    bus.temp_raw   = r;
    bus.temp_valid = 1'b1;
    @(negedge clk);
    bus.temp_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    tests++;
    if (bus.avg_valid !== v) begin
      fails++;
      $display("FAIL %s avg_valid: got %b, required %b", tag, bus.avg_valid, v);
    end
    if (v) begin
      tests++;
      if (bus.temp_avg !== 13'(a)) begin
        fails++;
        $display("FAIL %s temp_avg: got %0d, required %0d", tag, $signed(bus.temp_avg), a);
      end
    end
    @(negedge clk);
    tests++;
    if (bus.alarm !== al || bus.avg_valid !== 1'b0) begin
      fails++;
      $display("FAIL %s alarm: got %b (vld %b), required %b (vld 0)", tag, bus.alarm,
               bus.avg_valid, al);
    end
  endtask

  task automatic send_n(input int t, input int n, input string tag);
    for (int i = 0; i < n; i++) send_check(temp_to_raw(t), tag);
  endtask

  task automatic test_reset();
    bus.temp_raw   = '0;
    bus.temp_valid = 1'b0;
`ifdef ALARM_LATCH_EN
    bus.alarm_ack  = 1'b0;
`endif
    set_thr(int'(degC_to_code(28)), int'(degC_to_code(26)));
    apply_reset("reset");
  endtask

  task automatic test_fill();
    for (int i = 0; i < 4; i++) send_check(16'h0C80, "fill");
  endtask

  task automatic test_rise();
    send_n(480, 6, "rise");
  endtask

  task automatic test_hysteresis();
    send_n(430, 9, "hyst_hold");
    send_n(400, 2, "hyst_cool");
    send_n(430, 1, "hyst_bounce");
    send_n(400, 6, "hyst_leave");
  endtask

  task automatic test_signed();
    apply_reset("signed_rst");
    for (int i = 0; i < 4; i++) send_check(16'hFF80, "neg_fill");
    send_check(16'hFF80, "mix");
    send_check(16'hFF80, "mix");
    send_check(16'h0080, "mix");
    send_check(16'h0080, "mix");
    apply_reset("max_rst");
    for (int i = 0; i < 4; i++) send_check(16'h7FF8, "max");
    for (int i = 0; i < 4; i++) send_check(16'h8000, "min");
  endtask

  task automatic test_reset_mid();
    apply_reset("mid_rst0");
    send_n(400, 2, "mid_fill");
    apply_reset("mid_fill_rst");
    send_n(400, 3, "after_fill_rst");
    send_n(480, 1, "refill");
    send_n(480, 4, "mid_rise");
    apply_reset("mid_rise_rst");
    send_n(480, 3, "after_rise_rst");
    send_n(480, 3, "rise_again");
  endtask

  // Consecutive-cycle strobes: each sample must produce its own in-order result.
  task automatic test_back_to_back();
    localparam int K = 12;
    logic [15:0] rr [K];
    bit ev [K];
    int ea [K];
    bit eal [K];
    for (int i = 0; i < K; i++) begin
      rr[i] = temp_to_raw(int'($urandom_range(380, 500)));
      model_push(rr[i], ev[i], ea[i]);
      eal[i] = m_alarm | m_latch;
    end
    for (int c = 0; c < K + 4; c++) begin
      @(negedge clk);
      if (c >= 3 && c - 3 < K) begin
        tests++;
        if (bus.avg_valid !== ev[c-3] || (ev[c-3] && bus.temp_avg !== 13'(ea[c-3]))) begin
          fails++;
          $display("FAIL b2b[%0d] avg: got vld=%b avg=%0d, required vld=%b avg=%0d", c - 3,
                   bus.avg_valid, $signed(bus.temp_avg), ev[c-3], ea[c-3]);
        end
      end
      if (c >= 4 && c - 4 < K) begin
        tests++;
        if (bus.alarm !== eal[c-4]) begin
          fails++;
          $display("FAIL b2b[%0d] alarm: got %b, required %b", c - 4, bus.alarm, eal[c-4]);
        end
      end
      bus.temp_valid = (c < K);
      if (c < K) bus.temp_raw = rr[c];
    end
    bus.temp_valid = 1'b0;
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++)
      send_check(temp_to_raw(int'($urandom_range(360, 520))), "random");
  endtask

  task automatic test_inverted_thr();
    set_thr(416, 448);
    for (int i = 0; i < 20; i++)
      send_check(temp_to_raw(int'($urandom_range(380, 480))), "inv_thr");
    set_thr(448, 416);
  endtask

`ifdef ALARM_LATCH_EN
  task automatic ack_check(input string tag);
    @(negedge clk);
    bus.alarm_ack = 1'b1;
    @(negedge clk);
    bus.alarm_ack = 1'b0;
    if (!m_alarm && m_run == 0) m_latch = 1'b0;
    tests++;
    if (bus.alarm !== (m_alarm | m_latch)) begin
      fails++;
      $display("FAIL %s: alarm got %b, required %b", tag, bus.alarm, m_alarm | m_latch);
    end
  endtask

  task automatic test_latch();
    apply_reset("latch_rst");
    send_n(480, 6, "latch_enter");
    send_n(400, 6, "latch_cool");
    send_n(480, 2, "latch_rise");
    ack_check("ack_in_rise");
    send_n(400, 1, "latch_back");
    ack_check("ack_in_normal");
  endtask
`endif

  initial begin
    test_reset();
    test_fill();
    test_rise();
    test_hysteresis();
    test_signed();
    test_reset_mid();
    test_back_to_back();
    test_random();
    test_inverted_thr();
`ifdef ALARM_LATCH_EN
    test_latch();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
